// File: rtl/mp_icache_ctrl_v2_pkg.sv
// rtl/mp_icache_ctrl_v2_pkg.sv - register map, FSM encodings and arithmetic helpers for the icache control unit
package mp_icache_ctrl_v2_pkg;

    localparam logic [31:0] REG_ENABLE      = 32'h00;
    localparam logic [31:0] REG_FLUSH       = 32'h04;
    localparam logic [31:0] REG_SEL_FLUSH   = 32'h08;
    localparam logic [31:0] REG_STATUS      = 32'h0C;
    localparam logic [31:0] REG_CNT_CTRL    = 32'h10;
    localparam logic [31:0] REG_GLB_HIT     = 32'h14;
    localparam logic [31:0] REG_GLB_TRANS   = 32'h18;
    localparam logic [31:0] REG_GLB_MISS    = 32'h1C;
    localparam logic [31:0] REG_BANK_BASE   = 32'h20;
    localparam logic [31:0] REG_BANK_STRIDE = 32'h10;

    localparam int STAT_BYPASS     = 0;
    localparam int STAT_FLUSH_BUSY = 1;
    localparam int STAT_FIFO_EMPTY = 2;
    localparam int STAT_FIFO_FULL  = 3;
    localparam int STAT_COUNT_LSB  = 8;

    typedef enum logic [1:0] {
        FLUSH_IDLE     = 2'd0,
        FLUSH_WAIT_SEL = 2'd1,
        FLUSH_REQ      = 2'd2
    } flush_state_e;

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_REQ  = 1'b1
    } sel_state_e;

    // Number of set bits; 33-bit result so it adds directly into saturating sums.
    function automatic logic [32:0] popcount(input logic [31:0] v);
        logic [32:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 33'(v[i]);
        end
        return n;
    endfunction

    // Add and clamp at max; operands stay far below 2^33 so the sum cannot wrap.
    function automatic logic [32:0] sat_add(input logic [32:0] a, input logic [32:0] b,
                                            input logic [32:0] max);
        logic [32:0] s;
        s = a + b;
        return (s > max) ? max : s;
    endfunction

endpackage

// File: rtl/mp_icache_sel_fifo.sv
// rtl/mp_icache_sel_fifo.sv - selective-flush address queue with push, pop, clear and occupancy
module mp_icache_sel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; a clear discards everything and wins over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/mp_icache_ctrl_unit_v2.sv
// rtl/mp_icache_ctrl_unit_v2.sv - register-mapped bypass/flush/counter control for a shared instruction cache
module mp_icache_ctrl_unit_v2
    import mp_icache_ctrl_v2_pkg::*;
#(
    parameter int NB_CACHES      = 2,
    parameter int NB_BANKS       = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int SEL_FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  reg_req_i,
    input  logic                  reg_we_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic                  reg_gnt_o,
    output logic                  reg_rvalid_o,
    output logic [31:0]           reg_rdata_o,
    output logic                  bypass_req_o,
    input  logic [NB_CACHES-1:0]  bypass_ack_i,
    output logic                  flush_req_o,
    input  logic [NB_CACHES-1:0]  flush_ack_i,
    output logic                  sel_flush_req_o,
    output logic [31:0]           sel_flush_addr_o,
    input  logic [NB_CACHES-1:0]  sel_flush_ack_i,
    input  logic [NB_BANKS-1:0]   hit_i,
    input  logic [NB_BANKS-1:0]   trans_i,
    input  logic [NB_BANKS-1:0]   miss_i
);
    localparam int          FCW     = $clog2(SEL_FIFO_DEPTH) + 1;
    localparam logic [32:0] CNT_MAX = (33'd1 << CNT_WIDTH) - 33'd1;

    flush_state_e          r_flush_state, w_flush_next;
    sel_state_e            r_sel_state, w_sel_next;
    logic [NB_CACHES-1:0]  r_flush_ack_vec, r_sel_ack_vec;
    logic [31:0]           r_sel_addr, r_rdata, w_rd_data, w_status, w_addr, w_fifo_head;
    logic                  r_enable, r_cnt_en, r_rvalid;
    logic                  w_fifo_full, w_fifo_empty;
    logic [FCW-1:0]        w_fifo_count;
    logic                  w_wr, w_rd, w_flush_busy, w_flush_wr, w_flush_start, w_push;
    logic                  w_cnt_wr, w_cnt_clear, w_sel_wr_req;
    logic                  w_flush_ack_all, w_sel_ack_all, w_sel_done, w_sel_start;
    logic                  w_bypass_settled;
    logic [CNT_WIDTH-1:0]  r_glob_cnt [3];
    logic [CNT_WIDTH-1:0]  r_bank_cnt [3][NB_BANKS];
    logic [NB_BANKS-1:0]   w_ev [3];

    assign w_addr        = 32'(reg_addr_i);
    assign w_flush_busy  = (r_flush_state != FLUSH_IDLE);
    // A queued address cannot be accepted while the queue is full or a full flush will subsume it.
    assign w_sel_wr_req  = reg_req_i && reg_we_i && (w_addr == REG_SEL_FLUSH);
    assign reg_gnt_o     = reg_req_i && !(w_sel_wr_req && (w_fifo_full || w_flush_busy));
    assign w_wr          = reg_gnt_o && reg_we_i;
    assign w_rd          = reg_gnt_o && !reg_we_i;
    assign w_flush_wr    = w_wr && (w_addr == REG_FLUSH);
    assign w_flush_start = w_flush_wr && (r_flush_state == FLUSH_IDLE);
    assign w_push        = w_wr && (w_addr == REG_SEL_FLUSH);
    assign w_cnt_wr      = w_wr && (w_addr == REG_CNT_CTRL);
    assign w_cnt_clear   = w_cnt_wr && reg_wdata_i[1];

    assign w_flush_ack_all = &(r_flush_ack_vec | flush_ack_i);
    assign w_sel_ack_all   = &(r_sel_ack_vec | sel_flush_ack_i);
    assign w_sel_done      = (r_sel_state == SEL_REQ) && w_sel_ack_all;
    // Holding off on the flush-write cycle keeps a new selective flush from racing the FIFO clear.
    assign w_sel_start     = (r_sel_state == SEL_IDLE) && !w_fifo_empty &&
                             (r_flush_state == FLUSH_IDLE) && !w_flush_wr;

    assign bypass_req_o     = ~r_enable;
    assign flush_req_o      = (r_flush_state == FLUSH_REQ);
    assign sel_flush_req_o  = (r_sel_state == SEL_REQ);
    assign sel_flush_addr_o = r_sel_addr;
    assign reg_rvalid_o     = r_rvalid;
    assign reg_rdata_o      = r_rdata;
    assign w_bypass_settled = bypass_req_o ? (&bypass_ack_i) : ~(|bypass_ack_i);

    assign w_ev[0] = hit_i;
    assign w_ev[1] = trans_i;
    assign w_ev[2] = miss_i;

    mp_icache_sel_fifo #(.DEPTH(SEL_FIFO_DEPTH), .WIDTH(32)) u_sel_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_sel_done),
        .i_clear (w_flush_start),
        .i_wdata (reg_wdata_i),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Next-state logic for the full-flush and selective-flush sequencers.
    always_comb begin
        w_flush_next = r_flush_state;
        w_sel_next   = r_sel_state;
        case (r_flush_state)
            FLUSH_IDLE:     if (w_flush_wr) w_flush_next = (r_sel_state == SEL_REQ) ? FLUSH_WAIT_SEL : FLUSH_REQ;
            FLUSH_WAIT_SEL: if (w_sel_done || r_sel_state == SEL_IDLE) w_flush_next = FLUSH_REQ;
            FLUSH_REQ:      if (w_flush_ack_all) w_flush_next = FLUSH_IDLE;
            default:        w_flush_next = FLUSH_IDLE;
        endcase
        case (r_sel_state)
            SEL_IDLE: if (w_sel_start) w_sel_next = SEL_REQ;
            SEL_REQ:  if (w_sel_ack_all) w_sel_next = SEL_IDLE;
            default:  w_sel_next = SEL_IDLE;
        endcase
    end

    // Sequencer state, sticky ack collection and the latched selective-flush address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_state   <= FLUSH_IDLE;
            r_sel_state     <= SEL_IDLE;
            r_flush_ack_vec <= '0;
            r_sel_ack_vec   <= '0;
            r_sel_addr      <= '0;
        end else begin
            r_flush_state   <= w_flush_next;
            r_sel_state     <= w_sel_next;
            r_flush_ack_vec <= (flush_req_o && !w_flush_ack_all) ? (r_flush_ack_vec | flush_ack_i) : '0;
            r_sel_ack_vec   <= (sel_flush_req_o && !w_sel_ack_all) ? (r_sel_ack_vec | sel_flush_ack_i) : '0;
            if (w_sel_start) r_sel_addr <= w_fifo_head;
        end
    end

    // Control registers and the registered bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable <= 1'b0;
            r_cnt_en <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr && w_addr == REG_ENABLE) r_enable <= reg_wdata_i[0];
            if (w_cnt_wr)                     r_cnt_en <= reg_wdata_i[0];
            r_rvalid <= reg_gnt_o;
            r_rdata  <= w_rd ? w_rd_data : '0;
        end
    end

    // Saturating performance counters; clear beats any increment in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 3; k++) begin
                r_glob_cnt[k] <= '0;
                for (int b = 0; b < NB_BANKS; b++) r_bank_cnt[k][b] <= '0;
            end
        end else if (w_cnt_clear) begin
            for (int k = 0; k < 3; k++) begin
                r_glob_cnt[k] <= '0;
                for (int b = 0; b < NB_BANKS; b++) r_bank_cnt[k][b] <= '0;
            end
        end else if (r_cnt_en) begin
            for (int k = 0; k < 3; k++) begin
                r_glob_cnt[k] <= CNT_WIDTH'(sat_add(33'(r_glob_cnt[k]), popcount(32'(w_ev[k])), CNT_MAX));
                for (int b = 0; b < NB_BANKS; b++) begin
                    r_bank_cnt[k][b] <= CNT_WIDTH'(sat_add(33'(r_bank_cnt[k][b]), 33'(w_ev[k][b]), CNT_MAX));
                end
            end
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status                                   = '0;
        w_status[STAT_BYPASS]                      = w_bypass_settled;
        w_status[STAT_FLUSH_BUSY]                  = w_flush_busy;
        w_status[STAT_FIFO_EMPTY]                  = w_fifo_empty;
        w_status[STAT_FIFO_FULL]                   = w_fifo_full;
        w_status[STAT_COUNT_LSB +: 8]              = 8'(w_fifo_count);
    end

    // Read data decode; unmapped and write-only locations return zero.
    always_comb begin
        w_rd_data = '0;
        case (w_addr)
            REG_ENABLE:    w_rd_data = {31'b0, r_enable};
            REG_FLUSH:     w_rd_data = {31'b0, w_flush_busy};
            REG_STATUS:    w_rd_data = w_status;
            REG_CNT_CTRL:  w_rd_data = {31'b0, r_cnt_en};
            REG_GLB_HIT:   w_rd_data = 32'(r_glob_cnt[0]);
            REG_GLB_TRANS: w_rd_data = 32'(r_glob_cnt[1]);
            REG_GLB_MISS:  w_rd_data = 32'(r_glob_cnt[2]);
            default:       w_rd_data = '0;
        endcase
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int k = 0; k < 3; k++) begin
                if (w_addr == REG_BANK_BASE + 32'(b) * REG_BANK_STRIDE + 32'(4 * k))
                    w_rd_data = 32'(r_bank_cnt[k][b]);
            end
        end
    end
endmodule

// File: tb/tb_mp_icache_ctrl_unit_v2.sv
// tb/tb_mp_icache_ctrl_unit_v2.sv - directed self-checking bench for the icache control unit
module tb_mp_icache_ctrl_unit_v2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_req, reg_we;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        bypass_req, flush_req, sel_req;
    logic [31:0] sel_addr;
    logic [1:0]  bypass_ack, flush_ack, sel_ack;
    logic [3:0]  hit, trans, miss;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    mp_icache_ctrl_unit_v2 #(.NB_CACHES(2), .NB_BANKS(4), .CNT_WIDTH(4),
                             .SEL_FIFO_DEPTH(4), .ADDR_WIDTH(10)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
        .reg_gnt_o(gnt), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata),
        .bypass_req_o(bypass_req), .bypass_ack_i(bypass_ack),
        .flush_req_o(flush_req), .flush_ack_i(flush_ack),
        .sel_flush_req_o(sel_req), .sel_flush_addr_o(sel_addr), .sel_flush_ack_i(sel_ack),
        .hit_i(hit), .trans_i(trans), .miss_i(miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        #1;
        while (!gnt && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, {31'b0, gnt}, 32'h1);
    endtask

    task automatic bus_wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        wait_gnt("wr_gnt");
        @(posedge clk); #1;
        reg_req = 1'b0; reg_we = 1'b0;
        check("wr_rvalid", {31'b0, rvalid}, 32'h1);
    endtask

    task automatic bus_rd(input logic [9:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
        wait_gnt("rd_gnt");
        @(posedge clk); #1;
        reg_req = 1'b0;
        d = rdata;
    endtask

    task automatic wait_sel_req();
        int n;
        n = 0;
        while (!sel_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("sel_req_wait", {31'b0, sel_req}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; reg_req = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;
        bypass_ack = '0; flush_ack = '0; sel_ack = '0; hit = '0; trans = '0; miss = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;

        // Reset state
        check("rst_bypass", {31'b0, bypass_req}, 32'h1);
        check("rst_flush",  {31'b0, flush_req}, 32'h0);
        check("rst_sel",    {31'b0, sel_req}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        bus_rd(10'h00, rd); check("rd_enable_rst", rd, 32'h0);
        bus_rd(10'h0C, rd); check("rd_status_rst", rd, 32'h4);

        // Enable caches
        bus_wr(10'h00, 32'h1);
        check("bypass_off", {31'b0, bypass_req}, 32'h0);
        bus_rd(10'h0C, rd); check("status_settled", rd, 32'h5);
        bus_rd(10'h00, rd); check("rd_enable", rd, 32'h1);

        // Full flush with staggered acks
        bus_wr(10'h04, 32'hDEAD);
        check("flush_req_on", {31'b0, flush_req}, 32'h1);
        bus_rd(10'h04, rd); check("flush_busy", rd, 32'h1);
        @(negedge clk); flush_ack = 2'b01;
        @(negedge clk); flush_ack = 2'b00;
        @(negedge clk); @(negedge clk); #1;
        check("flush_req_hold", {31'b0, flush_req}, 32'h1);
        flush_ack = 2'b10;
        @(posedge clk); #1; flush_ack = 2'b00;
        check("flush_req_off", {31'b0, flush_req}, 32'h0);
        bus_rd(10'h0C, rd); check("status_flush_done", rd, 32'h5);

        // Selective flush queue back-pressure and ordering
        for (int i = 0; i < 4; i++) bus_wr(10'h08, 32'hA000_0000 + 32'(i) * 32'h10);
        bus_rd(10'h0C, rd); check("status_full", rd, 32'h0409);
        @(negedge clk);
        reg_req = 1; reg_we = 1; reg_addr = 10'h08; reg_wdata = 32'hA000_0040; #1;
        check("gnt_full", {31'b0, gnt}, 32'h0);
        check("sel_addr0", sel_addr, 32'hA000_0000);
        repeat (2) @(negedge clk); #1;
        check("gnt_full_hold", {31'b0, gnt}, 32'h0);
        sel_ack = 2'b11;
        @(posedge clk); #1; sel_ack = 2'b00;
        check("sel_req_drop", {31'b0, sel_req}, 32'h0);
        @(negedge clk); #1;
        check("gnt_space", {31'b0, gnt}, 32'h1);
        @(posedge clk); #1; reg_req = 0; reg_we = 0;
        for (int i = 1; i < 5; i++) begin
            wait_sel_req();
            check("sel_addr_order", sel_addr, 32'hA000_0000 + 32'(i) * 32'h10);
            if (i == 1) begin
                @(negedge clk); sel_ack = 2'b01;
                @(posedge clk); #1; sel_ack = 2'b00;
                check("sel_partial", {31'b0, sel_req}, 32'h1);
                @(negedge clk); sel_ack = 2'b10;
                @(posedge clk); #1; sel_ack = 2'b00;
            end else begin
                @(negedge clk); sel_ack = 2'b11;
                @(posedge clk); #1; sel_ack = 2'b00;
            end
        end
        bus_rd(10'h0C, rd); check("status_drained", rd, 32'h5);

        // Full flush waits for an in-flight selective flush and discards the queue
        bus_wr(10'h08, 32'h1000);
        bus_wr(10'h08, 32'h2000);
        bus_wr(10'h04, 32'h1);
        check("wait_sel_noflush", {31'b0, flush_req}, 32'h0);
        check("inflight_addr", sel_addr, 32'h1000);
        repeat (2) @(posedge clk); #1;
        check("wait_sel_hold", {31'b0, flush_req}, 32'h0);
        @(negedge clk); sel_ack = 2'b11;
        @(posedge clk); #1; sel_ack = 2'b00;
        check("flush_after_sel", {31'b0, flush_req}, 32'h1);
        @(negedge clk); flush_ack = 2'b11;
        @(posedge clk); #1; flush_ack = 2'b00;
        check("flush_done2", {31'b0, flush_req}, 32'h0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin @(posedge clk); #1; seen = seen | sel_req; end
            check("no_2000_issue", {31'b0, seen}, 32'h0);
        end
        bus_rd(10'h0C, rd); check("status_after_flush", rd, 32'h5);

        // Counters (CNT_WIDTH=4)
        bus_wr(10'h10, 32'h1);
        @(negedge clk); hit = 4'hF; trans = 4'b0101; miss = 4'b1000;
        @(negedge clk);
        @(negedge clk); miss = 4'h0;
        @(negedge clk); trans = 4'h0;
        @(negedge clk);
        @(negedge clk); hit = 4'h0;
        bus_rd(10'h14, rd); check("glb_hit_sat", rd, 32'hF);
        bus_rd(10'h20, rd); check("b0_hit", rd, 32'h5);
        bus_rd(10'h50, rd); check("b3_hit", rd, 32'h5);
        bus_rd(10'h18, rd); check("glb_trans", rd, 32'h6);
        bus_rd(10'h24, rd); check("b0_trans", rd, 32'h3);
        bus_rd(10'h34, rd); check("b1_trans", rd, 32'h0);
        bus_rd(10'h1C, rd); check("glb_miss", rd, 32'h2);
        bus_rd(10'h58, rd); check("b3_miss", rd, 32'h2);

        // Disabled counters hold
        bus_wr(10'h10, 32'h0);
        @(negedge clk); hit = 4'hF;
        @(negedge clk); hit = 4'h0;
        bus_rd(10'h20, rd); check("b0_hold", rd, 32'h5);

        // Clear beats a same-cycle hit
        bus_wr(10'h10, 32'h1);
        @(negedge clk);
        reg_req = 1; reg_we = 1; reg_addr = 10'h10; reg_wdata = 32'h3; hit = 4'hF;
        @(posedge clk); #1; reg_req = 0; reg_we = 0; hit = 4'h0;
        bus_rd(10'h20, rd); check("b0_cleared", rd, 32'h0);
        bus_rd(10'h14, rd); check("glb_cleared", rd, 32'h0);
        bus_rd(10'h10, rd); check("cnt_ctrl_rd", rd, 32'h1);
        @(negedge clk); hit = 4'h1;
        @(negedge clk); hit = 4'h0;
        bus_rd(10'h20, rd); check("b0_after_clr", rd, 32'h1);
        bus_rd(10'h30, rd); check("b1_after_clr", rd, 32'h0);

        // Unmapped locations
        bus_rd(10'h2C, rd); check("unmapped_2c", rd, 32'h0);
        bus_rd(10'h3FC, rd); check("unmapped_3fc", rd, 32'h0);
        bus_wr(10'h3FC, 32'h0);
        bus_rd(10'h00, rd); check("enable_kept", rd, 32'h1);

        // Reset mid-operation
        bus_wr(10'h08, 32'h3000);
        wait_sel_req();
        bus_wr(10'h04, 32'h1);
        @(negedge clk); rst_n = 1'b0; #1;
        check("rst_mid_sel",    {31'b0, sel_req}, 32'h0);
        check("rst_mid_flush",  {31'b0, flush_req}, 32'h0);
        check("rst_mid_bypass", {31'b0, bypass_req}, 32'h1);
        @(negedge clk); rst_n = 1'b1;
        bus_rd(10'h0C, rd); check("status_rst_mid", rd, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mp_icache_ctrl_unit_v2.md
Name: mp_icache_ctrl_unit_v2

Overview:
- Register-mapped control unit for a multi-instance, multi-bank shared instruction cache; sits between the cluster peripheral interconnect and the icache instances.
- Drives bypass, full flush and selective flush handshakes to NB_CACHES instances.
- Queues selective-flush addresses in a FIFO.
- Keeps per-bank and global saturating hit/transaction/miss counters with parametrised width.

Parameters:
- NB_CACHES, 2, number of icache instances receiving bypass/flush.
- NB_BANKS, 4, number of banks providing event pulses.
- CNT_WIDTH, 32, performance counter width (1..32).
- SEL_FIFO_DEPTH, 4, selective-flush address queue depth (power of 2, >=2).
- ADDR_WIDTH, 10, register byte-address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg_req_i  in  1  register access request
- reg_we_i  in  1  1 = write
- reg_addr_i  in  ADDR_WIDTH  byte address, word aligned
- reg_wdata_i  in  32  write data
- reg_gnt_o  out  1  request accepted
- reg_rvalid_o  out  1  response valid
- reg_rdata_o  out  32  read data
- bypass_req_o  out  1  level, 1 = caches bypassed
- bypass_ack_i  in  NB_CACHES  per-cache bypass state
- flush_req_o  out  1  full flush request
- flush_ack_i  in  NB_CACHES  per-cache flush done pulse
- sel_flush_req_o  out  1  selective flush request
- sel_flush_addr_o  out  32  address to invalidate
- sel_flush_ack_i  in  NB_CACHES  per-cache selective flush done pulse
- hit_i  in  NB_BANKS  per-bank hit pulse
- trans_i  in  NB_BANKS  per-bank transaction pulse
- miss_i  in  NB_BANKS  per-bank miss pulse

Behaviour:
- Reset: bypass_req_o=1; all other outputs 0; FIFO empty; counters 0; counting disabled; both FSMs IDLE.
- Register map (byte offsets):
  - 0x00 ENABLE: bit0; bypass_req_o = ~bit0.
  - 0x04 FLUSH: any write starts a full flush; read bit0 = flush busy.
  - 0x08 SEL_FLUSH: write pushes wdata into the FIFO.
  - 0x0C STATUS (read-only): bit0 bypass settled, bit1 flush busy, bit2 FIFO empty, bit3 FIFO full, [15:8] FIFO count.
  - 0x10 CNT_CTRL: bit0 count enable; bit1 clear, self-clearing, reads 0.
  - 0x14/0x18/0x1C: global hit/trans/miss.
  - 0x20+16*b +0/+4/+8: bank b hit/trans/miss.
  - Counters are read-only and zero-extended to 32 bits.
- Bus handshake:
  - reg_gnt_o = reg_req_i, except a SEL_FLUSH write while the FIFO is full or a flush is busy; gnt stays low until space frees.
  - reg_rvalid_o one cycle after gnt, also for writes.
  - reg_rdata_o registered; 0 for writes and unmapped addresses.
  - Unmapped writes are ignored.
- Bypass settled = (&bypass_ack_i) when bypass_req_o=1, else ~(|bypass_ack_i).
- Flush FSM states: IDLE, WAIT_SEL, REQ.
  - FLUSH write in IDLE: clear the FIFO (entries subsumed by the full flush). Go to WAIT_SEL if a selective flush is in flight, else REQ.
  - WAIT_SEL -> REQ once the selective flush completes.
  - REQ: flush_req_o=1 and a sticky ack vector collects flush_ack_i. When the vector is all ones, drop req, clear the vector, return to IDLE.
  - FLUSH write while busy: ignored.
- Selective FSM states: IDLE, REQ.
  - IDLE with FIFO non-empty and flush FSM in IDLE: sel_flush_req_o=1, sel_flush_addr_o = FIFO head, go to REQ.
  - REQ: sticky ack vector collects sel_flush_ack_i. When all ones, pop the FIFO and return to IDLE. Next request starts one cycle later at the earliest.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- Counters, when enabled:
  - Bank counter +1 per event pulse.
  - Global counter += popcount of the corresponding NB_BANKS vector.
  - All counters saturate at 2^CNT_WIDTH-1; no wrap.
  - Clear has priority over increments in the same cycle.
  - A disabled counter holds its value.
- Acks on non-requested channels are ignored.
- Reset mid-operation aborts both FSMs, empties the FIFO and drops all requests.

Decomposition:
- Package mp_icache_ctrl_v2_pkg holds:
  - register offset localparams;
  - flush_state_e and sel_state_e enums;
  - STATUS bit-index constants;
  - the popcount function.
- Sub-module mp_icache_sel_fifo: SEL_FIFO_DEPTH x 32 FIFO with push, pop, clear, full, empty and count.
- Counters and both FSMs stay in the top module.

Test Plan:
- Reset, read 0x00 and 0x0C -> 0x0 and 0x00000004; bypass_req_o=1. Write 0x00=1 -> bypass_req_o=0 next cycle; STATUS bit0=1 after all bypass_ack_i=0.
- Write FLUSH; acks for caches 0 and 1 arrive 3 cycles apart -> flush_req_o stays high until the second ack, then 0; STATUS bit1 falls.
- Push 5 addresses with DEPTH=4 and acks held off -> fifth gnt stays low; after the first ack, gnt rises; addresses are issued in push order.
- Push 0x1000 and 0x2000; write FLUSH while 0x1000 is in flight -> flush_req_o asserts only after the 0x1000 ack; 0x2000 is never issued.
- CNT_WIDTH=4, enable, hit_i=4'b1111 for 5 cycles -> each bank hit=5, global hit=15 (saturated).
- Clear and a hit pulse in the same cycle -> counter reads 0.
